// File: rtl/rtc_pkg.sv
// Shared constants, state encoding and read-sweep address table for the RTC
// transaction sequencer.
package rtc_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned TMR_W  = 12;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned RD_TABLE_LEN = 6;

  // Power-up init: two writes to the control register.
  localparam logic [ADDR_W-1:0] INIT_ADDR  = 8'h02;
  localparam logic [DATA_W-1:0] INIT0_DATA = 8'h10;
  localparam logic [DATA_W-1:0] INIT1_DATA = 8'h00;

  typedef enum logic [1:0] {
    INIT0,
    INIT1,
    INITW,
    IDLE
  } state_e;

  // Read sweep order: seconds, minutes, hours, day, month, year.
  function automatic logic [ADDR_W-1:0] rd_table(input logic [IDX_W-1:0] idx);
    logic [ADDR_W-1:0] a;
    case (idx)
      3'd0:    a = 8'h21;
      3'd1:    a = 8'h22;
      3'd2:    a = 8'h23;
      3'd3:    a = 8'h24;
      3'd4:    a = 8'h25;
      3'd5:    a = 8'h26;
      default: a = 8'h21;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Frame-tick counter that wraps every REFRESH_FRAMES ticks and flags the wrap
// in the same cycle as the frame_tick that causes it.
module rtc_refresh_timer
  import rtc_pkg::*;
#(
  parameter int unsigned REFRESH_FRAMES = 3125
) (
  input  logic reloj,
  input  logic resetM,
  input  logic frame_tick,
  output logic wrap
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(REFRESH_FRAMES - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  assign wrap = frame_tick && (cnt_q == LAST);

  // Advance on every frame boundary, wrapping after the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (frame_tick) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_secuenciador.sv
// RTC bus transaction sequencer: picks the transaction for each bus frame
// (init writes, user writes, periodic read sweep) and returns read data.
module rtc_secuenciador
  import rtc_pkg::*;
#(
  parameter int unsigned FRAME_CYC      = 32,
  parameter int unsigned REFRESH_FRAMES = 3125,
  parameter int unsigned N_RD           = 6
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic              frame_tick,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              le,
  output logic              bus_active,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              init_done,
  output logic              busy
);

  if (FRAME_CYC < 2 || N_RD < 1 || N_RD > RD_TABLE_LEN) begin : g_param_check
    $error("rtc_secuenciador: unsupported FRAME_CYC/N_RD");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RD - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              le_q, le_d;
  logic              act_q, act_d;
  logic              ack_q, ack_d;
  logic              rv_q, rv_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] rdt_q, rdt_d;
  logic              idn_q, idn_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              swa_q, swa_d;
  logic              swp_q, swp_d;
  logic              consume;
  logic              wrap;

  rtc_refresh_timer #(
    .REFRESH_FRAMES(REFRESH_FRAMES)
  ) u_timer (
    .reloj     (reloj),
    .resetM    (resetM),
    .frame_tick(frame_tick),
    .wrap      (wrap)
  );

  // Frame-boundary decision: read return, init sequence and arbitration.
  // A pending sweep is consumed when it starts, so a wrap arriving mid-sweep
  // stays latched and launches the next sweep once this one finishes.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    le_d    = le_q;
    act_d   = act_q;
    ack_d   = 1'b0;
    rv_d    = 1'b0;
    ra_d    = ra_q;
    rdt_d   = rdt_q;
    idn_d   = idn_q;
    idx_d   = idx_q;
    swa_d   = swa_q;
    consume = 1'b0;

    if (frame_tick) begin
      if (act_q && le_q) begin
        rv_d  = 1'b1;
        ra_d  = addr_q;
        rdt_d = rd_data_in;
      end

      case (state_q)
        INIT0: begin
          addr_d  = INIT_ADDR;
          wdata_d = INIT0_DATA;
          le_d    = 1'b0;
          act_d   = 1'b1;
          state_d = INIT1;
        end
        INIT1: begin
          addr_d  = INIT_ADDR;
          wdata_d = INIT1_DATA;
          le_d    = 1'b0;
          act_d   = 1'b1;
          state_d = INITW;
        end
        INITW: begin
          le_d    = 1'b1;
          act_d   = 1'b0;
          idn_d   = 1'b1;
          state_d = IDLE;
        end
        IDLE: begin
          if (wr_req) begin
            addr_d  = wr_addr;
            wdata_d = wr_data;
            le_d    = 1'b0;
            act_d   = 1'b1;
            ack_d   = 1'b1;
          end else if (swa_q || swp_q) begin
            addr_d  = rd_table(idx_q);
            le_d    = 1'b1;
            act_d   = 1'b1;
            consume = !swa_q;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              swa_d = 1'b0;
            end else begin
              idx_d = idx_q + 1'b1;
              swa_d = 1'b1;
            end
          end else begin
            le_d  = 1'b1;
            act_d = 1'b0;
          end
        end
        default: state_d = INIT0;
      endcase
    end

    swp_d = (swp_q && !consume) || wrap;
  end

  // Sequencer state and registered bus/return outputs.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state_q <= INIT0;
      addr_q  <= '0;
      wdata_q <= '0;
      le_q    <= 1'b1;
      act_q   <= 1'b0;
      ack_q   <= 1'b0;
      rv_q    <= 1'b0;
      ra_q    <= '0;
      rdt_q   <= '0;
      idn_q   <= 1'b0;
      idx_q   <= '0;
      swa_q   <= 1'b0;
      swp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      le_q    <= le_d;
      act_q   <= act_d;
      ack_q   <= ack_d;
      rv_q    <= rv_d;
      ra_q    <= ra_d;
      rdt_q   <= rdt_d;
      idn_q   <= idn_d;
      idx_q   <= idx_d;
      swa_q   <= swa_d;
      swp_q   <= swp_d;
    end
  end

  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign le         = le_q;
  assign bus_active = act_q;
  assign wr_ack     = ack_q;
  assign rd_valid   = rv_q;
  assign rd_addr    = ra_q;
  assign rd_data    = rdt_q;
  assign init_done  = idn_q;
  assign busy       = !idn_q || swa_q || swp_q || wr_req;

endmodule

// File: tb/tb_rtc_secuenciador.sv
// Directed bench for rtc_secuenciador with a short refresh period: init
// writes, held-off write during init, read sweeps, write interleave, sweep
// wrap during a sweep, and asynchronous reset mid-sweep.
module tb_rtc_secuenciador;

  localparam int KW = 0;
  localparam int KR = 1;
  localparam int KI = 2;

  typedef struct packed {
    logic       le;
    logic       act;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic       rv;
    logic [7:0] ra;
    logic [7:0] rdt;
    logic       idn;
  } obs_t;

  localparam obs_t RST_OBS = '{le: 1'b1, default: '0};

  logic       reloj;
  logic       resetM;
  logic       frame_tick;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [7:0] rd_data_in;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       le;
  logic       bus_active;
  logic       rd_valid;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       init_done;
  logic       busy;

  int unsigned vecs;
  int unsigned miscmp;
  int unsigned tick_no;
  obs_t        sb[$];

  logic [7:0] p_addr, p_wdata, p_ra, p_rdt;
  logic       p_rd;

  rtc_secuenciador #(
    .REFRESH_FRAMES(8)
  ) dut (
    .reloj     (reloj),
    .resetM    (resetM),
    .frame_tick(frame_tick),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_data_in(rd_data_in),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .le        (le),
    .bus_active(bus_active),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .init_done (init_done),
    .busy      (busy)
  );

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  function automatic obs_t observe();
    obs_t o;
    o = '{le: le, act: bus_active, addr: bus_addr, wdata: bus_wdata,
          ack: wr_ack, rv: rd_valid, ra: rd_addr, rdt: rd_data, idn: init_done};
    return o;
  endfunction

  task automatic check(input string tag, input logic [36:0] o, input logic [36:0] x);
    vecs++;
    assert (o === x) else begin
      miscmp++;
      $error("FAIL %s: observed %h expected %h", tag, o, x);
    end
  endtask

  task automatic reset_model();
    p_addr  = '0;
    p_wdata = '0;
    p_ra    = '0;
    p_rdt   = '0;
    p_rd    = 1'b0;
    tick_no = 0;
  endtask

  // One bus frame: expected frame contents are queued, then the tick is
  // driven and the registered result popped and compared, plus a mid-frame
  // hold check.
  task automatic frame(input int k, input logic [7:0] a, input logic [7:0] d,
                       input logic ack, input logic idn);
    obs_t       e, o, h;
    logic [7:0] din;
    din     = 8'($urandom);
    tick_no++;
    e.le    = (k != KW);
    e.act   = (k != KI);
    e.addr  = (k == KI) ? p_addr : a;
    e.wdata = (k == KW) ? d : p_wdata;
    e.ack   = ack;
    e.rv    = p_rd;
    e.ra    = p_rd ? p_addr : p_ra;
    e.rdt   = p_rd ? din : p_rdt;
    e.idn   = idn;
    sb.push_back(e);

    @(negedge reloj);
    frame_tick = 1'b1;
    rd_data_in = din;
    @(posedge reloj);
    #1;
    o = observe();
    e = sb.pop_front();
    check($sformatf("tick%0d", tick_no), o, e);

    @(negedge reloj);
    frame_tick = 1'b0;
    rd_data_in = 8'($urandom);
    if (ack) wr_req = 1'b0;
    repeat (15) @(negedge reloj);
    h     = e;
    h.ack = 1'b0;
    h.rv  = 1'b0;
    check($sformatf("hold%0d", tick_no), observe(), h);
    repeat (15) @(negedge reloj);

    p_addr  = e.addr;
    p_wdata = e.wdata;
    p_ra    = e.ra;
    p_rdt   = e.rdt;
    p_rd    = (k == KR);
  endtask

  initial begin
    vecs       = 0;
    miscmp     = 0;
    resetM     = 1'b0;
    frame_tick = 1'b0;
    wr_req     = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    rd_data_in = '0;
    reset_model();

    #12;
    check("reset", observe(), RST_OBS);
    check("reset_busy", 37'(busy), 37'(1'b1));
    @(negedge reloj);
    resetM = 1'b1;

    // User write held during init must wait until after init_done.
    wr_req  = 1'b1;
    wr_addr = 8'h30;
    wr_data = 8'h5A;
    frame(KW, 8'h02, 8'h10, 1'b0, 1'b0);
    frame(KW, 8'h02, 8'h00, 1'b0, 1'b0);
    frame(KI, 8'h00, 8'h00, 1'b0, 1'b1);
    frame(KW, 8'h30, 8'h5A, 1'b1, 1'b1);
    frame(KI, 8'h00, 8'h00, 1'b0, 1'b1);
    frame(KI, 8'h00, 8'h00, 1'b0, 1'b1);
    frame(KI, 8'h00, 8'h00, 1'b0, 1'b1);
    check("idle_busy", 37'(busy), 37'(1'b0));
    // Tick 8 wraps the refresh timer.
    frame(KI, 8'h00, 8'h00, 1'b0, 1'b1);
    check("pending_busy", 37'(busy), 37'(1'b1));

    // First sweep with a write interleaved after the 0x23 read.
    frame(KR, 8'h21, 8'h00, 1'b0, 1'b1);
    frame(KR, 8'h22, 8'h00, 1'b0, 1'b1);
    frame(KR, 8'h23, 8'h00, 1'b0, 1'b1);
    wr_req  = 1'b1;
    wr_addr = 8'h22;
    wr_data = 8'h45;
    frame(KW, 8'h22, 8'h45, 1'b1, 1'b1);
    frame(KR, 8'h24, 8'h00, 1'b0, 1'b1);
    frame(KR, 8'h25, 8'h00, 1'b0, 1'b1);
    frame(KR, 8'h26, 8'h00, 1'b0, 1'b1);
    frame(KI, 8'h00, 8'h00, 1'b0, 1'b1);

    // Second sweep stalled by three writes so the tick-24 wrap lands mid-sweep.
    frame(KR, 8'h21, 8'h00, 1'b0, 1'b1);
    frame(KR, 8'h22, 8'h00, 1'b0, 1'b1);
    frame(KR, 8'h23, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wr_req  = 1'b1;
      wr_addr = 8'(8'h40 + i);
      wr_data = 8'(i + 1);
      frame(KW, 8'(8'h40 + i), 8'(i + 1), 1'b1, 1'b1);
    end
    frame(KR, 8'h24, 8'h00, 1'b0, 1'b1);
    frame(KR, 8'h25, 8'h00, 1'b0, 1'b1);
    frame(KR, 8'h26, 8'h00, 1'b0, 1'b1);
    // Back-to-back follow-on sweep from the latched wrap.
    for (int i = 0; i < 6; i++) begin
      frame(KR, 8'(8'h21 + i), 8'h00, 1'b0, 1'b1);
    end
    frame(KI, 8'h00, 8'h00, 1'b0, 1'b1);
    frame(KR, 8'h21, 8'h00, 1'b0, 1'b1);
    frame(KR, 8'h22, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a read frame.
    #2;
    resetM = 1'b0;
    #1;
    check("async_reset", observe(), RST_OBS);
    check("async_reset_busy", 37'(busy), 37'(1'b1));
    repeat (3) @(negedge reloj);
    resetM = 1'b1;
    reset_model();
    frame(KW, 8'h02, 8'h10, 1'b0, 1'b0);
    frame(KW, 8'h02, 8'h00, 1'b0, 1'b0);
    frame(KI, 8'h00, 8'h00, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule

// File: doc/rtc_secuenciador.md
Name: rtc_secuenciador

Overview:
Transaction sequencer for the RTC multiplexed-bus handshake generator. It decides, frame by frame, which RTC bus transaction runs next: the power-up init writes, user write requests, or the periodic read sweep of the time/date registers. It drives the address, write data and read/write mode for each 32-cycle bus frame, and returns captured read data to the display path.

Parameters:
FRAME_CYC, 32, cycles per bus frame; informational, all timing is keyed to frame_tick.
REFRESH_FRAMES, 3125, frame_ticks between read-sweep starts (1 ms at 10 ns clock).
N_RD, 6, registers per read sweep.

Ports:
reloj  in  1  system clock, 100 MHz.
resetM  in  1  asynchronous, active-low reset.
frame_tick  in  1  one-cycle pulse at each bus-frame boundary; the enable_cont_32 output of the handshake generator.
wr_req  in  1  user write request; held high until wr_ack.
wr_addr  in  8  RTC register address for the write.
wr_data  in  8  data for the write.
wr_ack  out  1  one-cycle pulse when the write is launched.
rd_data_in  in  8  bus-capture data, valid at the frame_tick that ends a read frame.
bus_addr  out  8  address for the current frame.
bus_wdata  out  8  write data for the current frame.
le  out  1  1 = read frame, 0 = write frame.
bus_active  out  1  current frame carries a transaction.
rd_valid  out  1  one-cycle pulse; rd_addr/rd_data are valid.
rd_addr  out  8  address of the completed read.
rd_data  out  8  data of the completed read.
init_done  out  1  high once both init writes have completed.
busy  out  1  a sweep or init is in progress, or a write is pending.

Behaviour:
- Reset (async, resetM=0): all counters 0, state INIT0, bus_addr=0, bus_wdata=0, le=1, bus_active=0, wr_ack=0, rd_valid=0, rd_addr=0, rd_data=0, init_done=0, busy=1. Asserting reset mid-frame aborts the frame; init reruns after release.
- All decisions are made only in the cycle frame_tick=1. Selected values are registered and appear the next cycle. They are held constant for the whole frame, up to and including the next frame_tick cycle.
- States:
  - INIT0: at frame_tick, launch a write to 0x02 with data 0x10, then go to INIT1.
  - INIT1: at frame_tick, launch a write to 0x02 with data 0x00, then go to INITW.
  - INITW: at frame_tick, set init_done=1 and go to IDLE.
  - IDLE: see arbitration below.
- Arbitration at each frame_tick when init_done=1, in priority order:
  1. wr_req=1: latch wr_addr/wr_data, drive le=0 and bus_active=1, pulse wr_ack in the same cycle as the latch.
  2. Otherwise, if a sweep is in progress or sweep_pending=1: drive le=1 and bus_addr=RD_TABLE[idx], then increment idx. When the last entry (idx=N_RD-1) is issued, clear the sweep and sweep_pending.
  3. Otherwise: bus_active=0, le=1, bus_addr/bus_wdata hold their previous values.
- A pending write interleaves into a sweep at any frame boundary. The sweep resumes at the same idx on the next frame.
- Write requests arriving during INIT are held off; wr_ack is never issued before init_done=1.
- Read return: at the frame_tick that closes a read frame, set rd_data<=rd_data_in and rd_addr<=bus_addr, and pulse rd_valid for one cycle. This happens in the same cycle as the next frame's selection.
- Refresh timer: counts frame_ticks, 12-bit, from 0 to REFRESH_FRAMES-1, then wraps. On wrap it sets sweep_pending (saturating).
  - If the wrap occurs while a sweep is running, the flag is kept. A new sweep starts from idx 0 after the current one ends, with no overlap.
  - The timer runs from reset release, including during INIT.
- busy = ~init_done | sweep_active | sweep_pending | wr_req.
- Write frames (le=0) never produce rd_valid.

Decomposition:
- Package rtc_pkg:
  - RD_TABLE constants: 0x21 seconds, 0x22 minutes, 0x23 hours, 0x24 day, 0x25 month, 0x26 year.
  - INIT address/data pairs.
  - State encoding: INIT0, INIT1, INITW, IDLE.
  - Widths: ADDR_W=8, DATA_W=8.
- Sub-module rtc_refresh_timer: the frame-tick counter and the wrap pulse. Everything else stays in rtc_secuenciador.

Test Plan:
- Release reset, frame_tick every 32 cycles -> frame 1: le=0, addr 0x02, wdata 0x10; frame 2: addr 0x02, wdata 0x00; init_done=1 after the 3rd frame_tick.
- After init with REFRESH_FRAMES=8 -> six consecutive read frames with addresses 0x21..0x26. rd_valid pulses six times, each rd_addr matching the preceding frame and rd_data equal to rd_data_in at the closing tick.
- wr_req with addr 0x22, data 0x45 asserted during the sweep after the 0x23 read -> next frame is a write to 0x22 with wdata 0x45, le=0. wr_ack pulses once at that frame_tick, then the sweep resumes at 0x24.
- wr_req held during INIT0 -> no wr_ack until the frame_tick after init_done=1; init writes are unaffected.
- Refresh wrap forced during the 4th sweep read -> current sweep completes through 0x26, then a new sweep starts at 0x21 on the next frame, with no overlap.
- resetM pulsed low mid-sweep -> outputs return asynchronously to reset values, and INIT0 repeats after release.
